// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue: multi-lane retire buffer feeding Difftest commit probes.
// Retired lanes are packed in program order into a DEPTH-entry FIFO and drained
// up to COMMIT_WIDTH per cycle into registered commit lanes. A trap opcode
// (7'h6b) truncates its pop group, latches trap info and freezes the queue.
// Optional feature macro: COMMIT_SKIP_EN (per-entry difftest skip bit).

// Per-lane commit output register; holds its last value when not loaded.
module difftest_commit_lane #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ld,
  input  logic [XLEN-1:0] e_pc,
  input  logic [31:0]     e_inst,
  input  logic            e_wen,
  input  logic [4:0]      e_wdest,
  input  logic [XLEN-1:0] e_wdata,
`ifdef COMMIT_SKIP_EN
  input  logic            e_skip,
  output logic            cmt_skip,
`endif
  output logic [XLEN-1:0] cmt_pc,
  output logic [31:0]     cmt_inst,
  output logic            cmt_wen,
  output logic [7:0]      cmt_wdest,
  output logic [XLEN-1:0] cmt_wdata
);

  // Capture the head entry when this lane commits, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmt_pc    <= '0;
      cmt_inst  <= '0;
      cmt_wen   <= 1'b0;
      cmt_wdest <= '0;
      cmt_wdata <= '0;
`ifdef COMMIT_SKIP_EN
      cmt_skip  <= 1'b0;
`endif
    end else if (ld) begin
      cmt_pc    <= e_pc;
      cmt_inst  <= e_inst;
      cmt_wen   <= e_wen;
      cmt_wdest <= {3'b000, e_wdest};
      cmt_wdata <= e_wdata;
`ifdef COMMIT_SKIP_EN
      cmt_skip  <= e_skip;
`endif
    end
  end

endmodule

module difftest_commit_queue #(
  parameter int COMMIT_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int XLEN         = 64
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [COMMIT_WIDTH-1:0]               in_valid,
  input  logic [COMMIT_WIDTH-1:0][XLEN-1:0]     in_pc,
  input  logic [COMMIT_WIDTH-1:0][31:0]         in_inst,
  input  logic [COMMIT_WIDTH-1:0]               in_wen,
  input  logic [COMMIT_WIDTH-1:0][4:0]          in_wdest,
  input  logic [COMMIT_WIDTH-1:0][XLEN-1:0]     in_wdata,
  input  logic [COMMIT_WIDTH-1:0][7:0]          in_a0,
  input  logic [COMMIT_WIDTH-1:0]               in_skip,
  output logic                                  in_ready,
  output logic [COMMIT_WIDTH-1:0]               cmt_valid,
  output logic [COMMIT_WIDTH-1:0][XLEN-1:0]     cmt_pc,
  output logic [COMMIT_WIDTH-1:0][31:0]         cmt_inst,
  output logic [COMMIT_WIDTH-1:0]               cmt_wen,
  output logic [COMMIT_WIDTH-1:0][7:0]          cmt_wdest,
  output logic [COMMIT_WIDTH-1:0][XLEN-1:0]     cmt_wdata,
  output logic [COMMIT_WIDTH-1:0]               cmt_skip,
  output logic                                  trap_valid,
  output logic [7:0]                            trap_code,
  output logic [XLEN-1:0]                       trap_pc,
  output logic [63:0]                           cycle_cnt,
  output logic [63:0]                           instr_cnt,
  output logic                                  overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            wen;
    logic [4:0]      wdest;
    logic [XLEN-1:0] wdata;
    logic [7:0]      a0;
`ifdef COMMIT_SKIP_EN
    logic            skip;
`endif
  } ent_t;

  ent_t                          mem [DEPTH];
  ent_t [COMMIT_WIDTH-1:0]       new_ent, head;
  ent_t                          trap_ent;
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [CW-1:0]                 count;
  logic [COMMIT_WIDTH-1:0][2:0]  off;
  logic [2:0]                    push_n, pop_n, avail;
  logic [COMMIT_WIDTH-1:0]       cmt_mask;
  logic                          trap_seen, trap_hit, stop;

`ifndef COMMIT_SKIP_EN
  logic unused_skip;
  assign unused_skip = ^in_skip;
`endif

  // No same-cycle pop credit: a full group must fit against the pre-pop count.
  assign in_ready   = (count <= CW'(DEPTH - COMMIT_WIDTH)) && !trap_seen;
  assign trap_valid = trap_seen;

  // Compaction offsets and entry formatting for the incoming retire group.
  always_comb begin
    push_n  = '0;
    off     = '0;
    new_ent = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      off[i]           = push_n;
      push_n           = push_n + 3'(in_valid[i]);
      new_ent[i].pc    = in_pc[i];
      new_ent[i].inst  = in_inst[i];
      new_ent[i].wen   = in_wen[i];
      new_ent[i].wdest = in_wdest[i];
      new_ent[i].wdata = in_wdata[i];
      new_ent[i].a0    = in_a0[i];
`ifdef COMMIT_SKIP_EN
      new_ent[i].skip  = in_skip[i];
`endif
    end
    if (!in_ready) push_n = '0;
  end

  // Pop group: up to min(count, W) head entries, cut after the first trap.
  always_comb begin
    avail    = trap_seen ? 3'd0 :
               (count >= CW'(COMMIT_WIDTH)) ? 3'(COMMIT_WIDTH) : 3'(count);
    pop_n    = '0;
    trap_hit = 1'b0;
    trap_ent = '0;
    stop     = 1'b0;
    head     = '0;
    cmt_mask = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      head[i] = mem[rd_ptr + PW'(i)];
      if (!stop && (3'(i) < avail)) begin
        pop_n       = pop_n + 3'd1;
        cmt_mask[i] = 1'b1;
        if (head[i].inst[6:0] == 7'h6b) begin
          stop     = 1'b1;
          trap_hit = 1'b1;
          trap_ent = head[i];
        end
      end
    end
  end

  // FIFO storage writes; contents need no reset since count gates reads.
  always_ff @(posedge clock) begin
    if (in_ready) begin
      for (int i = 0; i < COMMIT_WIDTH; i++)
        if (in_valid[i]) mem[wr_ptr + PW'(off[i])] <= new_ent[i];
    end
  end

  // Pointers, occupancy, trap latch, sticky error and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      cmt_valid    <= '0;
      trap_seen    <= 1'b0;
      trap_code    <= '0;
      trap_pc      <= '0;
      cycle_cnt    <= '0;
      instr_cnt    <= '0;
      overflow_err <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(push_n);
      rd_ptr    <= rd_ptr + PW'(pop_n);
      count     <= count + CW'(push_n) - CW'(pop_n);
      cmt_valid <= cmt_mask;
      if (|in_valid && !in_ready) overflow_err <= 1'b1;
      if (trap_hit) begin
        trap_seen <= 1'b1;
        trap_code <= trap_ent.a0;
        trap_pc   <= trap_ent.pc;
      end
      if (!trap_seen) begin
        cycle_cnt <= cycle_cnt + 64'd1;
        instr_cnt <= instr_cnt + 64'(pop_n);
      end
    end
  end

  for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_lane
    difftest_commit_lane #(.XLEN(XLEN)) u_lane (
      .clock     (clock),
      .reset     (reset),
      .ld        (cmt_mask[g]),
      .e_pc      (head[g].pc),
      .e_inst    (head[g].inst),
      .e_wen     (head[g].wen),
      .e_wdest   (head[g].wdest),
      .e_wdata   (head[g].wdata),
`ifdef COMMIT_SKIP_EN
      .e_skip    (head[g].skip),
      .cmt_skip  (cmt_skip[g]),
`endif
      .cmt_pc    (cmt_pc[g]),
      .cmt_inst  (cmt_inst[g]),
      .cmt_wen   (cmt_wen[g]),
      .cmt_wdest (cmt_wdest[g]),
      .cmt_wdata (cmt_wdata[g])
    );
  end

`ifndef COMMIT_SKIP_EN
  assign cmt_skip = '0;
`endif

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed bench for difftest_commit_queue (W=2, DEPTH=8, XLEN=64, default build).
module tb_difftest_commit_queue;

  localparam int W = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [W-1:0]         in_valid;
  logic [W-1:0][63:0]   in_pc;
  logic [W-1:0][31:0]   in_inst;
  logic [W-1:0]         in_wen;
  logic [W-1:0][4:0]    in_wdest;
  logic [W-1:0][63:0]   in_wdata;
  logic [W-1:0][7:0]    in_a0;
  logic [W-1:0]         in_skip;
  logic                 in_ready;
  logic [W-1:0]         cmt_valid;
  logic [W-1:0][63:0]   cmt_pc;
  logic [W-1:0][31:0]   cmt_inst;
  logic [W-1:0]         cmt_wen;
  logic [W-1:0][7:0]    cmt_wdest;
  logic [W-1:0][63:0]   cmt_wdata;
  logic [W-1:0]         cmt_skip;
  logic                 trap_valid;
  logic [7:0]           trap_code;
  logic [63:0]          trap_pc;
  logic [63:0]          cycle_cnt;
  logic [63:0]          instr_cnt;
  logic                 overflow_err;

  int tests = 0;
  int fails = 0;

  difftest_commit_queue #(.COMMIT_WIDTH(W), .DEPTH(8), .XLEN(64)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_inst(in_inst), .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata),
    .in_a0(in_a0), .in_skip(in_skip), .in_ready(in_ready), .cmt_valid(cmt_valid),
    .cmt_pc(cmt_pc), .cmt_inst(cmt_inst), .cmt_wen(cmt_wen), .cmt_wdest(cmt_wdest),
    .cmt_wdata(cmt_wdata), .cmt_skip(cmt_skip), .trap_valid(trap_valid),
    .trap_code(trap_code), .trap_pc(trap_pc), .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt), .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    in_valid = '0; in_pc = '0; in_inst = '0; in_wen = '0;
    in_wdest = '0; in_wdata = '0; in_a0 = '0; in_skip = '0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", in_ready); end tests++;
    if (cmt_valid !== 2'b00) begin fails++; $display("FAIL reset_cmt_valid got=%b exp=00", cmt_valid); end tests++;
    if (trap_valid !== 1'b0 || overflow_err !== 1'b0) begin fails++;
      $display("FAIL reset_flags trap=%b ovf=%b exp=0,0", trap_valid, overflow_err); end tests++;
    if (cycle_cnt !== 64'd0 || instr_cnt !== 64'd0) begin fails++;
      $display("FAIL reset_counters cyc=%0d ins=%0d exp=0,0", cycle_cnt, instr_cnt); end tests++;
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 2'b01; in_pc[0] = 64'h8000_0000; in_inst[0] = 32'h0000_0013;
    in_wen[0] = 1'b1; in_wdest[0] = 5'd5; in_wdata[0] = 64'h1234;
    tick();
    clear_in();
    if (cmt_valid !== 2'b00) begin fails++; $display("FAIL single_early got=%b exp=00", cmt_valid); end tests++;
    tick();
    if (cmt_valid !== 2'b01) begin fails++; $display("FAIL single_valid got=%b exp=01", cmt_valid); end tests++;
    if (cmt_pc[0] !== 64'h8000_0000) begin fails++; $display("FAIL single_pc got=%h exp=80000000", cmt_pc[0]); end tests++;
    if (cmt_wdest[0] !== 8'd5 || cmt_wdata[0] !== 64'h1234 || cmt_wen[0] !== 1'b1) begin fails++;
      $display("FAIL single_wb wdest=%0d wdata=%h wen=%b exp=5,1234,1", cmt_wdest[0], cmt_wdata[0], cmt_wen[0]); end tests++;
    if (instr_cnt !== 64'd1 || cycle_cnt !== 64'd2) begin fails++;
      $display("FAIL single_cnt ins=%0d cyc=%0d exp=1,2", instr_cnt, cycle_cnt); end tests++;
    tick();
    if (cmt_valid !== 2'b00 || cmt_pc[0] !== 64'h8000_0000) begin fails++;
      $display("FAIL single_hold valid=%b pc=%h exp=00,80000000", cmt_valid, cmt_pc[0]); end tests++;
  endtask

  task automatic test_mask_order();
    do_reset();
    in_valid = 2'b10; in_pc[0] = 64'hdead; in_pc[1] = 64'h8000_0004;
    tick();
    in_valid = 2'b11; in_pc[0] = 64'h8000_0008; in_pc[1] = 64'h8000_000c;
    tick();
    clear_in();
    if (cmt_valid !== 2'b01 || cmt_pc[0] !== 64'h8000_0004) begin fails++;
      $display("FAIL mask_first valid=%b pc0=%h exp=01,80000004", cmt_valid, cmt_pc[0]); end tests++;
    tick();
    if (cmt_valid !== 2'b11) begin fails++; $display("FAIL mask_second_valid got=%b exp=11", cmt_valid); end tests++;
    if (cmt_pc[0] !== 64'h8000_0008 || cmt_pc[1] !== 64'h8000_000c) begin fails++;
      $display("FAIL mask_second_pc pc0=%h pc1=%h exp=80000008,8000000c", cmt_pc[0], cmt_pc[1]); end tests++;
    if (instr_cnt !== 64'd3) begin fails++; $display("FAIL mask_instr_cnt got=%0d exp=3", instr_cnt); end tests++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      if (e <= 4) begin
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready edge=%0d got=%b exp=1", e, in_ready); end tests++;
        in_valid = 2'b11;
        in_pc[0] = 64'h8000_1000 + 64'(8 * (e - 1));
        in_pc[1] = 64'h8000_1004 + 64'(8 * (e - 1));
        in_skip  = 2'b11;
      end else clear_in();
      tick();
      if (e >= 2) begin
        if (cmt_valid !== 2'b11 || cmt_pc[0] !== 64'h8000_1000 + 64'(8 * (e - 2)) ||
            cmt_pc[1] !== 64'h8000_1004 + 64'(8 * (e - 2))) begin fails++;
          $display("FAIL b2b_group edge=%0d valid=%b pc0=%h pc1=%h", e, cmt_valid, cmt_pc[0], cmt_pc[1]); end tests++;
        if (cmt_skip !== 2'b00) begin fails++; $display("FAIL b2b_skip got=%b exp=00", cmt_skip); end tests++;
      end
    end
    clear_in();
    if (instr_cnt !== 64'd8 || overflow_err !== 1'b0) begin fails++;
      $display("FAIL b2b_total ins=%0d ovf=%b exp=8,0", instr_cnt, overflow_err); end tests++;
  endtask

  task automatic test_trap_lane0();
    logic [63:0] cyc;
    do_reset();
    in_valid = 2'b11;
    in_pc[0] = 64'h8000_0010; in_inst[0] = 32'h0000_006b; in_a0[0] = 8'h00;
    in_pc[1] = 64'h8000_0014; in_inst[1] = 32'h0000_0013; in_a0[1] = 8'h55;
    tick();
    clear_in();
    tick();
    if (cmt_valid !== 2'b01 || cmt_pc[0] !== 64'h8000_0010) begin fails++;
      $display("FAIL trap0_commit valid=%b pc0=%h exp=01,80000010", cmt_valid, cmt_pc[0]); end tests++;
    if (trap_valid !== 1'b1 || trap_code !== 8'h00 || trap_pc !== 64'h8000_0010) begin fails++;
      $display("FAIL trap0_latch v=%b code=%h pc=%h exp=1,00,80000010", trap_valid, trap_code, trap_pc); end tests++;
    if (in_ready !== 1'b0 || instr_cnt !== 64'd1) begin fails++;
      $display("FAIL trap0_state ready=%b ins=%0d exp=0,1", in_ready, instr_cnt); end tests++;
    cyc = cycle_cnt;
    tick(); tick(); tick();
    if (cmt_valid !== 2'b00 || instr_cnt !== 64'd1 || cycle_cnt !== cyc) begin fails++;
      $display("FAIL trap0_frozen valid=%b ins=%0d cyc=%0d exp=00,1,%0d", cmt_valid, instr_cnt, cycle_cnt, cyc); end tests++;
    // Queue still holds the stranded lane-1 entry here; reset must discard everything.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (cmt_valid !== 2'b00 || trap_valid !== 1'b0 || overflow_err !== 1'b0 || in_ready !== 1'b1) begin fails++;
      $display("FAIL midreset valid=%b trap=%b ovf=%b ready=%b exp=00,0,0,1", cmt_valid, trap_valid, overflow_err, in_ready); end tests++;
    tick(); tick();
    if (cmt_valid !== 2'b00 || instr_cnt !== 64'd0) begin fails++;
      $display("FAIL midreset_empty valid=%b ins=%0d exp=00,0", cmt_valid, instr_cnt); end tests++;
  endtask

  task automatic test_trap_lane1_overflow();
    do_reset();
    in_valid = 2'b11;
    in_pc[0] = 64'h8000_0020; in_inst[0] = 32'h0000_0013; in_a0[0] = 8'h11;
    in_pc[1] = 64'h8000_0024; in_inst[1] = 32'h0000_006b; in_a0[1] = 8'h2a;
    tick();
    clear_in();
    tick();
    if (cmt_valid !== 2'b11 || trap_pc !== 64'h8000_0024 || trap_code !== 8'h2a) begin fails++;
      $display("FAIL trap1_latch valid=%b pc=%h code=%h exp=11,80000024,2a", cmt_valid, trap_pc, trap_code); end tests++;
    if (instr_cnt !== 64'd2 || overflow_err !== 1'b0) begin fails++;
      $display("FAIL trap1_cnt ins=%0d ovf=%b exp=2,0", instr_cnt, overflow_err); end tests++;
    in_valid = 2'b01; in_pc[0] = 64'h8000_0028;
    tick();
    clear_in();
    tick();
    if (overflow_err !== 1'b1 || cmt_valid !== 2'b00 || instr_cnt !== 64'd2) begin fails++;
      $display("FAIL overflow ovf=%b valid=%b ins=%0d exp=1,00,2", overflow_err, cmt_valid, instr_cnt); end tests++;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    test_reset();
    test_single();
    test_mask_order();
    test_back_to_back();
    test_trap_lane0();
    test_trap_lane1_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
